control_sequencer: RTL and testbench

Parametrised multicycle control unit for the soft CPU. It fetches one instruction word per instruction through a req/ack port and resolves each operand as an immediate, an ACC reference or a data-memory address. It then executes ALU, move and conditional-jump operations and writes results back to ACC or memory. It sits between the instruction store and the data memory, owns the instruction pointer and the accumulator, and replaces the earlier single-cycle control matrix, which had fixed widths and a delay-based memory read.

---
 rtl/control_pkg.sv | 57 +++++
 rtl/control_alu.sv | 50 +++++
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 tb/tb_control_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states
// and slicing helpers for the {op, f1, v1, f2, v2} instruction word.
package control_pkg;

    localparam int MAX_W = 64;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_NEG  = 3;
    localparam int OP_MOV  = 4;
    localparam int OP_JFE  = 5;
    localparam int OP_JFL  = 6;
    localparam int OP_JFG  = 7;
    localparam int OP_HALT = 63;

    localparam logic [MAX_W-1:0] ACC_SEL = '1;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_RD1,
        ST_RD2,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    function automatic logic [MAX_W-1:0] field(input logic [MAX_W-1:0] ir,
                                               input int lsb, input int width);
        logic [MAX_W-1:0] mask;
        for (int i = 0; i < MAX_W; i++) mask[i] = (i < width);
        return (ir >> lsb) & mask;
    endfunction

    // Word layout from the LSB: v2 (aw bits), f2, v1 (aw bits), f1, op.
    function automatic logic [MAX_W-1:0] get_op(input logic [MAX_W-1:0] ir, input int aw);
        return field(ir, 2*aw + 2, MAX_W);
    endfunction

    function automatic logic [MAX_W-1:0] get_f1(input logic [MAX_W-1:0] ir, input int aw);
        return field(ir, 2*aw + 1, 1);
    endfunction

    function automatic logic [MAX_W-1:0] get_v1(input logic [MAX_W-1:0] ir, input int aw);
        return field(ir, aw + 1, aw);
    endfunction

    function automatic logic [MAX_W-1:0] get_f2(input logic [MAX_W-1:0] ir, input int aw);
        return field(ir, aw, 1);
    endfunction

    function automatic logic [MAX_W-1:0] get_v2(input logic [MAX_W-1:0] ir, input int aw);
        return field(ir, 0, aw);
    endfunction

endpackage

// File: rtl/control_alu.sv
// Combinational datapath: arithmetic result, zero/carry flags and the
// jump condition for one instruction. Holds no state.
module control_alu
    import control_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] o1_i,
    input  logic [DATA_W-1:0] o2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o,
    output logic              jump_taken_o
);

    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    // The extra top bit is carry out for ADD and borrow out for SUB.
    assign sum_w  = {1'b0, o1_i} + {1'b0, o2_i};
    assign diff_w = {1'b0, o1_i} - {1'b0, o2_i};

    always_comb begin
        result_o     = '0;
        c_o          = 1'b0;
        jump_taken_o = 1'b0;
        case (op_i)
            OP_W'(OP_NOP): result_o = '0;
            OP_W'(OP_ADD): begin
                result_o = sum_w[DATA_W-1:0];
                c_o      = sum_w[DATA_W];
            end
            OP_W'(OP_SUB): begin
                result_o = diff_w[DATA_W-1:0];
                c_o      = diff_w[DATA_W];
            end
            OP_W'(OP_NEG): result_o = '0 - o1_i;
            OP_W'(OP_MOV): result_o = o1_i;
            OP_W'(OP_JFE): jump_taken_o = (o1_i == '0);
            OP_W'(OP_JFL): jump_taken_o = o1_i[DATA_W-1];
            OP_W'(OP_JFG): jump_taken_o = !o1_i[DATA_W-1] && (o1_i != '0);
            default: result_o = '0;
        endcase
    end

    assign z_o = (result_o == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control unit: fetches an instruction word, resolves operands
// (immediate, ACC or memory), executes via control_alu and writes back.
module control_sequencer
    import control_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [ADDR_W-1:0]              instr_addr,
    output logic                           instr_req,
    input  logic                           instr_ack,
    input  logic [OP_W+2*(ADDR_W+1)-1:0]   instr_data,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_rd,
    output logic                           mem_wr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_ack,
    output logic [DATA_W-1:0]              acc,
    output logic                           flag_z,
    output logic                           flag_c,
    output logic                           halted,
    output logic                           illegal
);

    localparam int INSTR_W = OP_W + 2*(ADDR_W+1);
    localparam logic [ADDR_W-1:0] ACC_SEL_A = ADDR_W'(ACC_SEL);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d, c_q, c_d;
    logic                halted_q, halted_d, illegal_q, illegal_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   o1_q, o1_d, o2_q, o2_d, res_q, res_d;

    logic [MAX_W-1:0]    ir_ext;
    logic [OP_W-1:0]     op;
    logic                f1, f2;
    logic [ADDR_W-1:0]   v1, v2;
    logic                op1_mem, op2_mem, op2_acc, uses_o2, writes_dest, op_legal;
    logic [DATA_W-1:0]   o1_val, o2_val, alu_res;
    logic                alu_z, alu_c, alu_jump;

    assign ir_ext = MAX_W'(ir_q);
    assign op     = OP_W'(get_op(ir_ext, ADDR_W));
    assign f1     = (get_f1(ir_ext, ADDR_W) != '0);
    assign v1     = ADDR_W'(get_v1(ir_ext, ADDR_W));
    assign f2     = (get_f2(ir_ext, ADDR_W) != '0);
    assign v2     = ADDR_W'(get_v2(ir_ext, ADDR_W));

    assign op1_mem     = f1 && (v1 != ACC_SEL_A);
    assign op2_mem     = f2 && (v2 != ACC_SEL_A);
    assign op2_acc     = f2 && (v2 == ACC_SEL_A);
    assign uses_o2     = (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_SUB)) ||
                         (op == OP_W'(OP_JFE)) || (op == OP_W'(OP_JFL)) ||
                         (op == OP_W'(OP_JFG));
    assign writes_dest = (op == OP_W'(OP_NEG)) || (op == OP_W'(OP_MOV));
    assign op_legal    = (op <= OP_W'(OP_JFG)) || (op == OP_W'(OP_HALT));

    // ACC is only modified in EXEC, so reading acc_q here gives the pre-execute value.
    assign o1_val = !f1 ? DATA_W'(v1) : (op1_mem ? o1_q : acc_q);
    assign o2_val = !f2 ? DATA_W'(v2) : (op2_mem ? o2_q : acc_q);

    control_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op_i         (op),
        .o1_i         (o1_val),
        .o2_i         (o2_val),
        .result_o     (alu_res),
        .z_o          (alu_z),
        .c_o          (alu_c),
        .jump_taken_o (alu_jump)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ip_q      <= '0;
            acc_q     <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            ir_q      <= '0;
            o1_q      <= '0;
            o2_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            acc_q     <= acc_d;
            z_q       <= z_d;
            c_q       <= c_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            ir_q      <= ir_d;
            o1_q      <= o1_d;
            o2_q      <= o2_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        acc_d     = acc_q;
        z_d       = z_q;
        c_d       = c_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        ir_d      = ir_q;
        o1_d      = o1_q;
        o2_d      = o2_q;
        res_d     = res_q;
        case (state_q)
            ST_FETCH: if (instr_ack) begin
                ir_d    = instr_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (op1_mem)                 state_d = ST_RD1;
                else if (op2_mem && uses_o2) state_d = ST_RD2;
                else                         state_d = ST_EXEC;
            end
            ST_RD1: if (mem_ack) begin
                o1_d    = mem_rdata;
                state_d = (op2_mem && uses_o2) ? ST_RD2 : ST_EXEC;
            end
            ST_RD2: if (mem_ack) begin
                o2_d    = mem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ip_d  = alu_jump ? ADDR_W'(o2_val) : ip_q + ADDR_W'(1);
                res_d = alu_res;
                if ((op == OP_W'(OP_ADD)) || (op == OP_W'(OP_SUB))) begin
                    acc_d = alu_res;
                    z_d   = alu_z;
                    c_d   = alu_c;
                end
                if (writes_dest && op2_acc) acc_d = alu_res;
                if (!op_legal) illegal_d = 1'b1;
                if (op == OP_W'(OP_HALT)) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (writes_dest && op2_mem) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB: if (mem_ack) state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign instr_req  = (state_q == ST_FETCH);
    assign instr_addr = ip_q;
    assign mem_rd     = (state_q == ST_RD1) || (state_q == ST_RD2);
    assign mem_wr     = (state_q == ST_WB);
    assign mem_addr   = (state_q == ST_RD1) ? v1 : v2;
    assign mem_wdata  = res_q;
    assign acc        = acc_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Drives control_sequencer with directed and random instructions and checks
// it against an instruction-level reference model of the ISA.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instr_addr;
    logic        instr_req;
    logic        instr_ack = 1'b0;
    logic [23:0] instr_data = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  acc;
    logic        flag_z, flag_c, halted, illegal;

    control_sequencer #(.DATA_W(8), .ADDR_W(8), .OP_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .acc        (acc),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] dmem [256];
    logic [7:0] mdmem[256];

    int m_ip, m_acc;
    bit m_z, m_c, m_halt, m_ill;
    int exp_rd[$];
    bit exp_wr_v;
    int exp_wr_a, exp_wr_d;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] enc(input int op, input int f1, input int v1,
                                        input int f2, input int v2);
        return {op[5:0], f1[0], v1[7:0], f2[0], v2[7:0]};
    endfunction

    task automatic model_reset();
        m_ip = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_ill = 0;
    endtask

    // ISA-level effect of one instruction on the model state.
    task automatic model_step(input logic [23:0] ins);
        int op, f1, v1, f2, v2, a, b, r;
        bit taken;
        op = int'(ins[23:18]); f1 = int'(ins[17]); v1 = int'(ins[16:9]);
        f2 = int'(ins[8]);     v2 = int'(ins[7:0]);
        exp_rd.delete();
        exp_wr_v = 0;
        taken = 0;
        b = 0;
        if (f1 == 0)        a = v1;
        else if (v1 == 255) a = m_acc;
        else begin a = int'(mdmem[v1]); exp_rd.push_back(v1); end
        if (op inside {1, 2, 5, 6, 7}) begin
            if (f2 == 0)        b = v2;
            else if (v2 == 255) b = m_acc;
            else begin b = int'(mdmem[v2]); exp_rd.push_back(v2); end
        end else if (f2 == 0) begin
            b = v2;
        end else begin
            b = (v2 == 255) ? m_acc : int'(mdmem[v2]);
        end
        case (op)
            1: begin r = a + b; m_c = (r > 255); m_acc = r % 256; m_z = (m_acc == 0); end
            2: begin m_c = (a < b); m_acc = (a - b + 256) % 256; m_z = (m_acc == 0); end
            3, 4: begin
                r = (op == 3) ? (256 - a) % 256 : a;
                if (f2 == 1) begin
                    if (v2 == 255) m_acc = r;
                    else begin
                        exp_wr_v = 1; exp_wr_a = v2; exp_wr_d = r;
                        mdmem[v2] = 8'(r);
                    end
                end
            end
            5: taken = (a == 0);
            6: taken = (a >= 128);
            7: taken = (a > 0) && (a < 128);
            0: ;
            63: m_halt = 1;
            default: m_ill = 1;
        endcase
        m_ip = taken ? (b % 256) : (m_ip + 1) % 256;
    endtask

    // Called at a negedge with the DUT fetching; returns at the negedge of the
    // next fetch (or once halted). Memory acks come after dly wait cycles.
    task automatic exec_instr(input logic [23:0] ins, input int dly);
        int cycles, wait_c, extra, ea;
        bit wr_seen;
        check_val("instr_req", int'(instr_req), 1);
        check_val("ip", int'(instr_addr), m_ip);
        model_step(ins);
        extra = (exp_rd.size() + (exp_wr_v ? 1 : 0)) * (dly + 1);
        instr_ack = 1'b1;
        instr_data = ins;
        cycles = 0; wait_c = 0; wr_seen = 0;
        forever begin
            @(negedge clock);
            instr_ack = 1'b0;
            instr_data = 24'($urandom);
            mem_ack = 1'b0;
            cycles++;
            if (instr_req || halted || cycles > 200) break;
            if (mem_rd) begin
                ea = (exp_rd.size() > 0) ? exp_rd[0] : 32'hFFFF;
                check_val("rd_addr", int'(mem_addr), ea);
                if (wait_c == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = dmem[mem_addr];
                    if (exp_rd.size() > 0) void'(exp_rd.pop_front());
                    wait_c = 0;
                end else begin
                    mem_rdata = 8'($urandom);
                    wait_c++;
                end
            end else if (mem_wr) begin
                check_val("wr_addr", int'(mem_addr), exp_wr_v ? exp_wr_a : 32'hFFFF);
                check_val("wr_data", int'(mem_wdata), exp_wr_v ? exp_wr_d : 32'hFFFF);
                if (wait_c == dly) begin
                    mem_ack = 1'b1;
                    dmem[mem_addr] = mem_wdata;
                    wr_seen = 1;
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end
        end
        mem_ack = 1'b0;
        check_val("latency", cycles, 3 + extra);
        check_val("acc", int'(acc), m_acc);
        check_val("flag_z", int'(flag_z), int'(m_z));
        check_val("flag_c", int'(flag_c), int'(m_c));
        check_val("halted", int'(halted), int'(m_halt));
        check_val("illegal", int'(illegal), int'(m_ill));
        check_val("rd_left", exp_rd.size(), 0);
        check_val("wr_done", int'(wr_seen), int'(exp_wr_v));
        $display("instr %06h dly %0d -> ip %02h acc %02h z %0d c %0d lat %0d",
                 ins, dly, m_ip, m_acc, m_z, m_c, cycles);
    endtask

    function automatic int rand_v();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 255;
        if (k == 1) return $urandom_range(0, 15);
        return $urandom_range(0, 255);
    endfunction

    function automatic logic [23:0] rand_instr();
        int k, op;
        k = $urandom_range(0, 19);
        if (k <= 7)       op = k;
        else if (k <= 16) op = $urandom_range(1, 4);
        else              op = $urandom_range(8, 62);
        return enc(op, $urandom_range(0, 1), rand_v(), $urandom_range(0, 1), rand_v());
    endfunction

    initial begin
        logic [7:0] b8;
        int guard;
        for (int i = 0; i < 256; i++) begin
            b8 = 8'($urandom);
            dmem[i] = b8;
            mdmem[i] = b8;
        end
        model_reset();

        // Reset held three cycles, then the first fetch appears at address 0.
        repeat (3) @(negedge clock);
        check_val("rst_rd", int'(mem_rd), 0);
        check_val("rst_wr", int'(mem_wr), 0);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_acc", int'(acc), 0);
        check_val("rst_flags", int'({flag_z, flag_c}), 0);
        check_val("rst_status", int'({halted, illegal}), 0);

        exec_instr(24'h040A03, 0);
        exec_instr(enc(2, 0, 2, 0, 5), 0);
        exec_instr(enc(1, 0, 255, 0, 1), 0);

        dmem[8'h10] = 8'h7E;
        mdmem[8'h10] = 8'h7E;
        exec_instr(enc(4, 1, 8'h10, 1, 8'h20), 2);

        exec_instr(enc(4, 0, 8'hFD, 1, 255), 0);
        exec_instr(enc(6, 1, 255, 0, 8'h40), 0);
        exec_instr(enc(4, 0, 8'h08, 1, 255), 0);
        exec_instr(enc(6, 1, 255, 0, 8'h40), 0);
        exec_instr(enc(5, 0, 0, 0, 8'hFF), 0);
        exec_instr(enc(5, 0, 0, 0, 8'h33), 0);
        exec_instr(enc(5, 0, 0, 0, 8'hFF), 0);
        exec_instr(enc(5, 0, 1, 0, 8'h33), 0);
        exec_instr(enc(8'h2A, 0, 1, 0, 2), 0);

        for (int i = 0; i < 120; i++) exec_instr(rand_instr(), $urandom_range(0, 2));

        // HALT: no requests afterwards even if acks keep arriving.
        exec_instr(enc(63, 0, 0, 0, 0), 0);
        instr_ack = 1'b1;
        mem_ack = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check_val("halt_idle", int'({instr_req, mem_rd, mem_wr}), 0);
        end
        instr_ack = 1'b0;
        mem_ack = 1'b0;

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_val("halt_clr", int'(halted), 0);
        exec_instr(enc(8'h2A, 0, 3, 0, 4), 0);

        // Reset while a writeback waits for its ack.
        check_val("ip", int'(instr_addr), m_ip);
        instr_ack = 1'b1;
        instr_data = enc(4, 0, 8'h55, 1, 8'h30);
        guard = 0;
        do begin
            @(negedge clock);
            instr_ack = 1'b0;
            guard++;
        end while (!mem_wr && guard < 10);
        check_val("wb_req", int'(mem_wr), 1);
        @(negedge clock);
        check_val("wb_hold", int'(mem_wr), 1);
        check_val("wb_addr", int'(mem_addr), 8'h30);
        check_val("wb_data", int'(mem_wdata), 8'h55);
        reset = 1'b1;
        @(negedge clock);
        check_val("wb_drop", int'(mem_wr), 0);
        check_val("rst2_status", int'({halted, illegal}), 0);
        check_val("rst2_acc", int'(acc), 0);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        model_reset();
        check_val("late_ack", int'(dmem[8'h30]), int'(mdmem[8'h30]));
        exec_instr(24'h040A03, 1);
        exec_instr(enc(2, 1, 255, 1, 8'h05), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
